// File: rtl/mul_pipe2_if.sv
// Handshake and payload bundle for the two-stage significand multiplier.
interface mul_pipe2_if #(
    parameter int unsigned SIGN_W = 1,
    parameter int unsigned EXPO_W = 8,
    parameter int unsigned MANT_W = 23
);
    localparam int unsigned SIG_W  = MANT_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned PEXP_W = EXPO_W + 2;

    logic              in_valid;
    logic              in_ready;
    logic [SIGN_W-1:0] a_sign;
    logic [SIGN_W-1:0] b_sign;
    logic [EXPO_W-1:0] a_expo;
    logic [EXPO_W-1:0] b_expo;
    logic [MANT_W-1:0] a_mant;
    logic [MANT_W-1:0] b_mant;
    logic              a_is_sub;
    logic              b_is_sub;
    logic              a_is_n0;
    logic              b_is_n0;
    logic              r_isnan;
    logic              is_inf_nan;
    logic              r_is0nan;

    logic              out_valid;
    logic              out_ready;
    logic [SIGN_W-1:0] p_sign;
    logic [PEXP_W-1:0] p_expo;
    logic [PROD_W-1:0] p_prod;
    logic              p_zero;
    logic              p_isnan;
    logic              p_inf_nan;
    logic              p_is0nan;

    modport master (
        output in_valid, a_sign, b_sign, a_expo, b_expo, a_mant, b_mant,
               a_is_sub, b_is_sub, a_is_n0, b_is_n0, r_isnan, is_inf_nan, r_is0nan,
               out_ready,
        input  in_ready, out_valid, p_sign, p_expo, p_prod, p_zero,
               p_isnan, p_inf_nan, p_is0nan
    );

    modport slave (
        input  in_valid, a_sign, b_sign, a_expo, b_expo, a_mant, b_mant,
               a_is_sub, b_is_sub, a_is_n0, b_is_n0, r_isnan, is_inf_nan, r_is0nan,
               out_ready,
        output in_ready, out_valid, p_sign, p_expo, p_prod, p_zero,
               p_isnan, p_inf_nan, p_is0nan
    );
endinterface

// File: rtl/mul_pipe2.sv
// Two-stage FP significand multiplier: S1 preps operands and forms split partial
// products, S2 sums them; valid/ready elastic pipeline with no skid buffer.
module mul_pipe2 #(
    parameter int unsigned SIGN_W = 1,
    parameter int unsigned EXPO_W = 8,
    parameter int unsigned MANT_W = 23
) (
    input  logic         clk,
    input  logic         rst_n,
    mul_pipe2_if.slave   bus
);
    localparam int unsigned SIG_W  = MANT_W + 1;
    localparam int unsigned H      = SIG_W / 2;
    localparam int unsigned HI_W   = SIG_W - H;
    localparam int unsigned LO_W   = SIG_W + H;
    localparam int unsigned HP_W   = SIG_W + HI_W;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned PEXP_W = EXPO_W + 2;
    localparam int unsigned BIAS   = (1 << (EXPO_W - 1)) - 1;

    logic s1_load;
    logic s2_load;

    logic v1_q, v1_d;
    logic v2_q, v2_d;

    logic [SIGN_W-1:0] s1_sign_q, s1_sign_d;
    logic [PEXP_W-1:0] s1_expo_q, s1_expo_d;
    logic [LO_W-1:0]   s1_lo_q,   s1_lo_d;
    logic [HP_W-1:0]   s1_hi_q,   s1_hi_d;
    logic              s1_zero_q, s1_zero_d;
    logic              s1_nan_q,  s1_nan_d;
    logic              s1_inf_q,  s1_inf_d;
    logic              s1_z0n_q,  s1_z0n_d;

    logic [SIGN_W-1:0] s2_sign_q, s2_sign_d;
    logic [PEXP_W-1:0] s2_expo_q, s2_expo_d;
    logic [PROD_W-1:0] s2_prod_q, s2_prod_d;
    logic              s2_zero_q, s2_zero_d;
    logic              s2_nan_q,  s2_nan_d;
    logic              s2_inf_q,  s2_inf_d;
    logic              s2_z0n_q,  s2_z0n_d;

    logic [SIG_W-1:0]  a_sig;
    logic [SIG_W-1:0]  b_sig;
    logic [EXPO_W-1:0] a_eff;
    logic [EXPO_W-1:0] b_eff;

    // Back-pressure chain; in_ready is forced high while reset holds both stages empty.
    assign s2_load      = !v2_q || bus.out_ready;
    assign s1_load      = !v1_q || s2_load;
    assign bus.in_ready = !rst_n || s1_load;

    // Operand prep: hidden bit from subnormal flag, subnormals use exponent 1.
    always_comb begin
        a_sig = {~bus.a_is_sub, bus.a_mant};
        b_sig = {~bus.b_is_sub, bus.b_mant};
        a_eff = bus.a_is_sub ? EXPO_W'(1) : bus.a_expo;
        b_eff = bus.b_is_sub ? EXPO_W'(1) : bus.b_expo;
    end

    always_comb begin
        v1_d      = v1_q;
        s1_sign_d = s1_sign_q;
        s1_expo_d = s1_expo_q;
        s1_lo_d   = s1_lo_q;
        s1_hi_d   = s1_hi_q;
        s1_zero_d = s1_zero_q;
        s1_nan_d  = s1_nan_q;
        s1_inf_d  = s1_inf_q;
        s1_z0n_d  = s1_z0n_q;
        if (s1_load) begin
            v1_d      = bus.in_valid;
            s1_sign_d = bus.a_sign ^ bus.b_sign;
            s1_expo_d = PEXP_W'(a_eff) + PEXP_W'(b_eff) - PEXP_W'(BIAS);
            s1_lo_d   = LO_W'(a_sig) * LO_W'(b_sig[H-1:0]);
            s1_hi_d   = HP_W'(a_sig) * HP_W'(b_sig[SIG_W-1:H]);
            s1_zero_d = bus.a_is_n0 | bus.b_is_n0;
            s1_nan_d  = bus.r_isnan;
            s1_inf_d  = bus.is_inf_nan;
            s1_z0n_d  = bus.r_is0nan;
        end
    end

    // Recombine the upper partial product at its H-bit offset.
    always_comb begin
        v2_d      = v2_q;
        s2_sign_d = s2_sign_q;
        s2_expo_d = s2_expo_q;
        s2_prod_d = s2_prod_q;
        s2_zero_d = s2_zero_q;
        s2_nan_d  = s2_nan_q;
        s2_inf_d  = s2_inf_q;
        s2_z0n_d  = s2_z0n_q;
        if (s2_load) begin
            v2_d      = v1_q;
            s2_sign_d = s1_sign_q;
            s2_expo_d = s1_expo_q;
            s2_prod_d = PROD_W'(s1_lo_q) + (PROD_W'(s1_hi_q) << H);
            s2_zero_d = s1_zero_q;
            s2_nan_d  = s1_nan_q;
            s2_inf_d  = s1_inf_q;
            s2_z0n_d  = s1_z0n_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            s1_sign_q <= '0;
            s1_expo_q <= '0;
            s1_lo_q   <= '0;
            s1_hi_q   <= '0;
            s1_zero_q <= 1'b0;
            s1_nan_q  <= 1'b0;
            s1_inf_q  <= 1'b0;
            s1_z0n_q  <= 1'b0;
            s2_sign_q <= '0;
            s2_expo_q <= '0;
            s2_prod_q <= '0;
            s2_zero_q <= 1'b0;
            s2_nan_q  <= 1'b0;
            s2_inf_q  <= 1'b0;
            s2_z0n_q  <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            s1_sign_q <= s1_sign_d;
            s1_expo_q <= s1_expo_d;
            s1_lo_q   <= s1_lo_d;
            s1_hi_q   <= s1_hi_d;
            s1_zero_q <= s1_zero_d;
            s1_nan_q  <= s1_nan_d;
            s1_inf_q  <= s1_inf_d;
            s1_z0n_q  <= s1_z0n_d;
            s2_sign_q <= s2_sign_d;
            s2_expo_q <= s2_expo_d;
            s2_prod_q <= s2_prod_d;
            s2_zero_q <= s2_zero_d;
            s2_nan_q  <= s2_nan_d;
            s2_inf_q  <= s2_inf_d;
            s2_z0n_q  <= s2_z0n_d;
        end
    end

    assign bus.out_valid = v2_q;
    assign bus.p_sign    = s2_sign_q;
    assign bus.p_expo    = s2_expo_q;
    assign bus.p_prod    = s2_prod_q;
    assign bus.p_zero    = s2_zero_q;
    assign bus.p_isnan   = s2_nan_q;
    assign bus.p_inf_nan = s2_inf_q;
    assign bus.p_is0nan  = s2_z0n_q;
endmodule

// File: tb/tb_mul_pipe2.sv
// Randomized bench for mul_pipe2 against a queue-based transaction model, plus directed FP32 cases.
module tb_mul_pipe2;
    localparam int unsigned SIGN_W = 1;
    localparam int unsigned EXPO_W = 8;
    localparam int unsigned MANT_W = 23;
    localparam int          BIAS   = 127;

    typedef struct {
        logic        as, bs;
        logic [7:0]  ae, be;
        logic [22:0] am, bm;
        logic        asub, bsub, an0, bn0;
        logic        nan, infn, zn;
    } op_t;

    typedef struct {
        logic        sign;
        logic [9:0]  expo;
        logic [47:0] prod;
        logic        zero, nan, infn, zn;
        int          acc;
    } res_t;

    logic clk;
    logic rst_n;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    res_t q[$];
    bit   smp_rst = 1'b0;
    bit   smp_acc = 1'b0;
    bit   smp_dep = 1'b0;
    op_t  smp_op;

    mul_pipe2_if #(.SIGN_W(SIGN_W), .EXPO_W(EXPO_W), .MANT_W(MANT_W)) bus ();

    mul_pipe2 #(.SIGN_W(SIGN_W), .EXPO_W(EXPO_W), .MANT_W(MANT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: real-valued significand product and unbiased exponent sum.
    function automatic res_t model(input op_t o, input int acc);
        res_t r;
        longint unsigned sa, sb;
        int ea, eb;
        sa = {40'd0, ~o.asub, o.am};
        sb = {40'd0, ~o.bsub, o.bm};
        ea = o.asub ? 1 : int'(o.ae);
        eb = o.bsub ? 1 : int'(o.be);
        r.prod = 48'(sa * sb);
        r.expo = 10'(ea + eb - BIAS);
        r.sign = o.as ^ o.bs;
        r.zero = o.an0 | o.bn0;
        r.nan  = o.nan;
        r.infn = o.infn;
        r.zn   = o.zn;
        r.acc  = acc;
        return r;
    endfunction

    function automatic op_t zero_op();
        op_t o;
        o.as = 0; o.bs = 0; o.ae = 0; o.be = 0; o.am = 0; o.bm = 0;
        o.asub = 0; o.bsub = 0; o.an0 = 0; o.bn0 = 0;
        o.nan = 0; o.infn = 0; o.zn = 0;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.as   = 1'($urandom());
        o.bs   = 1'($urandom());
        o.ae   = 8'($urandom_range(0, 255));
        o.be   = 8'($urandom_range(0, 255));
        o.am   = 23'($urandom());
        o.bm   = 23'($urandom());
        o.asub = (o.ae == 8'd0);
        o.bsub = (o.be == 8'd0);
        o.an0  = ($urandom_range(0, 7) == 0);
        o.bn0  = ($urandom_range(0, 7) == 0);
        o.nan  = 1'($urandom());
        o.infn = 1'($urandom());
        o.zn   = 1'($urandom());
        return o;
    endfunction

    function automatic op_t capture();
        op_t o;
        o.as = bus.a_sign; o.bs = bus.b_sign;
        o.ae = bus.a_expo; o.be = bus.b_expo;
        o.am = bus.a_mant; o.bm = bus.b_mant;
        o.asub = bus.a_is_sub; o.bsub = bus.b_is_sub;
        o.an0 = bus.a_is_n0; o.bn0 = bus.b_is_n0;
        o.nan = bus.r_isnan; o.infn = bus.is_inf_nan; o.zn = bus.r_is0nan;
        return o;
    endfunction

    task automatic apply(input op_t o);
        bus.a_sign = o.as; bus.b_sign = o.bs;
        bus.a_expo = o.ae; bus.b_expo = o.be;
        bus.a_mant = o.am; bus.b_mant = o.bm;
        bus.a_is_sub = o.asub; bus.b_is_sub = o.bsub;
        bus.a_is_n0 = o.an0; bus.b_is_n0 = o.bn0;
        bus.r_isnan = o.nan; bus.is_inf_nan = o.infn; bus.r_is0nan = o.zn;
    endtask

    // Present one op and hold it until accepted (bounded), then deassert.
    task automatic send(input op_t o);
        bit ok;
        ok = 1'b0;
        apply(o);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Per-cycle check of handshake and payload against the transaction model.
    always @(negedge clk) begin
        if (mon_en) begin
            int  n;
            bit  exp_ir, exp_ov;
            n      = q.size();
            exp_ir = !rst_n || (n < 2) || bus.out_ready;
            exp_ov = (n > 0) && (cyc - q[0].acc >= 2);
            chk("in_ready", 64'(bus.in_ready), 64'(exp_ir));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
            if (bus.out_valid && n > 0) begin
                chk("p_prod",    64'(bus.p_prod),    64'(q[0].prod));
                chk("p_expo",    64'(bus.p_expo),    64'(q[0].expo));
                chk("p_sign",    64'(bus.p_sign),    64'(q[0].sign));
                chk("p_zero",    64'(bus.p_zero),    64'(q[0].zero));
                chk("p_isnan",   64'(bus.p_isnan),   64'(q[0].nan));
                chk("p_inf_nan", 64'(bus.p_inf_nan), 64'(q[0].infn));
                chk("p_is0nan",  64'(bus.p_is0nan),  64'(q[0].zn));
            end
        end
        smp_rst = rst_n;
        smp_acc = rst_n && bus.in_valid && bus.in_ready;
        smp_dep = bus.out_valid && bus.out_ready;
        smp_op  = capture();
    end

    always @(posedge clk) begin
        if (!smp_rst) begin
            q.delete();
        end else begin
            if (smp_dep && q.size() > 0) void'(q.pop_front());
            if (smp_acc) q.push_back(model(smp_op, cyc));
        end
        cyc++;
        mon_en = 1'b1;
    end

    initial begin
        op_t o_one, o_m15, o_sub, o_zn;

        o_one = zero_op(); o_one.ae = 8'd127; o_one.be = 8'd127;
        o_m15 = o_one; o_m15.as = 1'b1; o_m15.am = 23'h400000; o_m15.bm = 23'h400000;
        o_sub = o_one; o_sub.ae = 8'd0; o_sub.am = 23'd1; o_sub.asub = 1'b1;
        o_zn  = o_one; o_zn.an0 = 1'b1; o_zn.nan = 1'b1;

        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        apply(zero_op());
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_p_prod",    64'(bus.p_prod),    64'd0);
        chk("rst_p_expo",    64'(bus.p_expo),    64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(o_one);
        chk("one_lat1_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        chk("one_valid", 64'(bus.out_valid), 64'd1);
        chk("one_prod",  64'(bus.p_prod), 64'h4000_0000_0000);
        chk("one_expo",  64'(bus.p_expo), 64'd127);
        chk("one_sign",  64'(bus.p_sign), 64'd0);

        send(o_m15);
        @(posedge clk); #1;
        chk("m15_prod", 64'(bus.p_prod), 64'h9000_0000_0000);
        chk("m15_expo", 64'(bus.p_expo), 64'd127);
        chk("m15_sign", 64'(bus.p_sign), 64'd1);

        send(o_sub);
        @(posedge clk); #1;
        chk("sub_prod", 64'(bus.p_prod), 64'h80_0000);
        chk("sub_expo", 64'(bus.p_expo), 64'd1);

        send(o_zn);
        @(posedge clk); #1;
        chk("zn_zero",  64'(bus.p_zero),  64'd1);
        chk("zn_isnan", 64'(bus.p_isnan), 64'd1);
        repeat (2) @(posedge clk);
        #1;

        // Back-pressure: two accepted, third blocked, then drain in order.
        bus.out_ready = 1'b0;
        apply(o_one); bus.in_valid = 1'b1;
        @(posedge clk); #1;
        apply(o_m15);
        @(posedge clk); #1;
        apply(o_sub);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_hold_prod", 64'(bus.p_prod), 64'h4000_0000_0000);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_d2_prod", 64'(bus.p_prod), 64'h9000_0000_0000);
        @(posedge clk); #1;
        chk("bp_d3_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_d3_prod", 64'(bus.p_prod), 64'h80_0000);
        @(posedge clk); #1;
        chk("bp_empty", 64'(bus.out_valid), 64'd0);

        // Reset one cycle after an accept discards the transaction.
        send(o_one);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_valid", 64'(bus.out_valid), 64'd0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 600; i++) begin
            apply(rand_op());
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst_n         = ($urandom_range(0, 199) != 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mul_pipe2.md
MUL_PIPE2 -- requirements
Module: mul_pipe2

Interface
REQ-001 Parameters SHALL be:
- SIGN_W, default 1, sign width
- EXPO_W, default 8, exponent width
- MANT_W, default 23, stored mantissa width
REQ-002 Clock and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream unpack/classify result valid
- in_ready  out  1  block accepts input this cycle
- a_sign, b_sign  in  1 each  operand signs
- a_expo, b_expo  in  EXPO_W each  biased exponents
- a_mant, b_mant  in  MANT_W each  stored mantissas
- a_is_sub, b_is_sub  in  1 each  operand subnormal
- a_is_n0, b_is_n0  in  1 each  operand is +/-0
- r_isnan, is_inf_nan, r_is0nan  in  1 each  special-case flags from classify stage
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- p_sign  out  1  product sign
- p_expo  out  EXPO_W+2  signed unbiased-sum exponent
- p_prod  out  2*(MANT_W+1)  raw significand product
- p_zero  out  1  product is exact zero
- p_isnan, p_inf_nan, p_is0nan  out  1 each  forwarded special flags

Function
REQ-004 The block SHALL be a two-register pipeline: S1 (operand prep + partial products), S2 (product sum), each with its own valid bit v1, v2.
REQ-005 Latency SHALL be exactly 2 cycles from an accepted input (in_valid && in_ready) to out_valid with no backpressure; throughput SHALL be 1 result per cycle.
REQ-006 Significand SHALL be sig = {~is_sub, mant} (MANT_W+1 bits); effective exponent SHALL be 1 when is_sub, else expo.
REQ-007 S1 SHALL register p_sign = a_sign ^ b_sign.
REQ-008 S1 SHALL register exp_sum = ea + eb - (2^(EXPO_W-1)-1), computed in EXPO_W+2-bit two's complement without truncation.
REQ-009 S1 SHALL register partial products a_sig*b_sig[H-1:0] and a_sig*b_sig[MANT_W:H], where H = (MANT_W+1)/2 (integer division).
REQ-010 S1 SHALL register p_zero = a_is_n0 | b_is_n0, together with the three special flags unchanged.
REQ-011 S2 SHALL compute p_prod = lo + (hi << H), width 2*(MANT_W+1), exact; S2 SHALL forward all other S1 fields unchanged.
REQ-012 When p_zero=1, p_prod and p_expo SHALL still be the arithmetic result; downstream uses the flag.
REQ-013 Stall rule: S2 SHALL load when !v2 || out_ready; S1 SHALL load when !v1 || (S2 loads).
REQ-014 in_ready SHALL equal the S1 load condition; it SHALL be combinational from out_ready, with no skid buffer.
REQ-015 S2 load SHALL set v2 = v1; S1 load SHALL set v1 = in_valid.
REQ-016 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-017 Simultaneous drain and fill (both stages full, out_ready=1, in_valid=1) SHALL advance both stages with no bubble.
REQ-018 Data registers SHALL not be required to hold when their valid is 0; outputs are only meaningful when out_valid=1.

Reset
REQ-019 On rst_n=0 at a clk edge, v1, v2, and all data registers SHALL clear to 0, so out_valid=0 and every output is 0 the cycle after reset.
REQ-020 in_ready SHALL be 1 during and after reset, since both stages are empty.
REQ-021 Reset mid-operation SHALL discard in-flight transactions, with no output produced for them.

Verification
REQ-022 FP32 1.0*1.0 (expo 127, mant 0 both), out_ready=1 -> out_valid 2 cycles later, p_prod=0x400000000000, p_expo=127, p_sign=0.
REQ-023 FP32 -1.5*1.5 (mant 0x400000, a_sign=1) -> p_prod=0x900000000000, p_expo=127, p_sign=1.
REQ-024 Subnormal a (expo 0, mant 1, a_is_sub=1) * 1.0 -> p_prod=0x800000, p_expo=1.
REQ-025 Backpressure: 3 back-to-back inputs with out_ready=0 -> in_ready=0 after 2 accepted; result 1 held stable; raising out_ready drains all 3 in order on consecutive cycles.
REQ-026 Zero and flags: a_is_n0=1 with r_isnan=1 -> p_zero=1 and p_isnan=1 two cycles later.
REQ-027 Reset mid-operation: rst_n=0 one cycle after an accept -> out_valid never asserts for it; in_ready=1 after reset.
